failure_counter: RTL and testbench

FAILURE_COUNTER -- requirements
Module: failure_counter

---
 rtl/failure_counter_pkg.sv | 24 ++
 rtl/sat_event_counter.sv | 58 +++++
 rtl/failure_counter.sv | 111 +++++++++++
 tb/tb_failure_counter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/failure_counter_pkg.sv
// Shared definitions for the failure counter: FSM encoding, default
// parameter values and the timer sizing helper.
package failure_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } fc_state_t;

  localparam int unsigned FC_CNT_W_DEF         = 16;
  localparam int unsigned FC_SETTLE_CYCLES_DEF = 16;
  localparam int unsigned FC_WINDOW_CYCLES_DEF = 8192;

  // One spare bit above clog2 of the longer phase so the timer never wraps.
  function automatic int unsigned fc_timer_width(input int unsigned settle,
                                                 input int unsigned window);
    int unsigned longest;
    longest = (settle > window) ? settle : window;
    return $clog2(longest) + 1;
  endfunction

endpackage

// File: rtl/sat_event_counter.sv
// Per-channel path: two-flop synchronizer, rising-edge detect and a
// saturating event counter with a sticky saturation flag.
module sat_event_counter
  import failure_counter_pkg::*;
#(
  parameter int unsigned CNT_W = FC_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_err,
  input  logic             i_clear,
  input  logic             i_count_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_sat
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_count;
  logic             r_sat;
  logic             w_event;
  logic [CNT_W-1:0] w_count_inc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_err;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_event     = r_sync2 & ~r_prev;
  assign w_count_inc = r_count + 1'b1;

  // Saturation is flagged on the edge that lands on all-ones; the flag then
  // blocks further increments so the counter cannot wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (i_clear) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (i_count_en && w_event && !r_sat) begin
      r_count <= w_count_inc;
      r_sat   <= &w_count_inc;
    end
  end

  assign o_count = r_count;
  assign o_sat   = r_sat;

endmodule

// File: rtl/failure_counter.sv
// Measurement controller: settle, then count error events on two channels
// over a fixed window, and hold the results until the next start.
module failure_counter
  import failure_counter_pkg::*;
#(
  parameter int unsigned CNT_W         = FC_CNT_W_DEF,
  parameter int unsigned SETTLE_CYCLES = FC_SETTLE_CYCLES_DEF,
  parameter int unsigned WINDOW_CYCLES = FC_WINDOW_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             error_1,
  input  logic             error_2,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] fail_count_1,
  output logic [CNT_W-1:0] fail_count_2,
  output logic             sat_1,
  output logic             sat_2,
  output logic             any_fail
);

  localparam int unsigned TMR_W = fc_timer_width(SETTLE_CYCLES, WINDOW_CYCLES);
  localparam logic [TMR_W-1:0] SETTLE_LAST =
    TMR_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST =
    TMR_W'((WINDOW_CYCLES == 0) ? 0 : WINDOW_CYCLES - 1);
  localparam fc_state_t ENTRY_STATE = (SETTLE_CYCLES == 0) ? ST_COUNT : ST_SETTLE;

  fc_state_t        r_state;
  fc_state_t        w_state_nxt;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_nxt;
  logic             w_clear;
  logic             w_count_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Start is honoured in every state, so it is handled ahead of the case.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_clear     = 1'b0;
    if (start) begin
      w_state_nxt = ENTRY_STATE;
      w_timer_nxt = '0;
      w_clear     = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: ;
        ST_SETTLE: begin
          if (r_timer == SETTLE_LAST) begin
            w_state_nxt = ST_COUNT;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
        ST_COUNT: begin
          if (r_timer == WINDOW_LAST) begin
            w_state_nxt = ST_DONE;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
        ST_DONE: ;
        default: begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

  assign w_count_en = (r_state == ST_COUNT);

  sat_event_counter #(.CNT_W(CNT_W)) u_chan_1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_err      (error_1),
    .i_clear    (w_clear),
    .i_count_en (w_count_en),
    .o_count    (fail_count_1),
    .o_sat      (sat_1)
  );

  sat_event_counter #(.CNT_W(CNT_W)) u_chan_2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_err      (error_2),
    .i_clear    (w_clear),
    .i_count_en (w_count_en),
    .o_count    (fail_count_2),
    .o_sat      (sat_2)
  );

  assign busy     = (r_state == ST_SETTLE) || (r_state == ST_COUNT);
  assign done     = (r_state == ST_DONE);
  assign any_fail = (|fail_count_1) || (|fail_count_2);

endmodule

// File: tb/tb_failure_counter.sv
// Directed bench: default-parameter instance for the main scenarios and a
// small instance (CNT_W=4, no settle, 64-cycle window) for saturation/edges.
module tb_failure_counter;
  import failure_counter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start_a, e1_a, e2_a;
  logic        busy_a, done_a, sat1_a, sat2_a, anyf_a;
  logic [15:0] fc1_a, fc2_a;

  logic        start_b, e1_b, e2_b;
  logic        busy_b, done_b, sat1_b, sat2_b, anyf_b;
  logic [3:0]  fc1_b, fc2_b;

  int n_vec  = 0;
  int n_fail = 0;

  failure_counter u_a (
    .clk(clk), .reset_n(reset_n), .start(start_a),
    .error_1(e1_a), .error_2(e2_a),
    .busy(busy_a), .done(done_a),
    .fail_count_1(fc1_a), .fail_count_2(fc2_a),
    .sat_1(sat1_a), .sat_2(sat2_a), .any_fail(anyf_a)
  );

  failure_counter #(.CNT_W(4), .SETTLE_CYCLES(0), .WINDOW_CYCLES(64)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start_b),
    .error_1(e1_b), .error_2(e2_b),
    .busy(busy_b), .done(done_b),
    .fail_count_1(fc1_b), .fail_count_2(fc2_b),
    .sat_1(sat1_b), .sat_2(sat2_b), .any_fail(anyf_b)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    start_a = 1'b0; e1_a = 1'b0; e2_a = 1'b0;
    start_b = 1'b0; e1_b = 1'b0; e2_b = 1'b0;
    tick(3);

    // reset state
    chk("rst_state", u_a.r_state, ST_IDLE);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_fc1", fc1_a, 16'd0);
    chk("rst_fc2", fc2_a, 16'd0);
    chk("rst_sat", {sat1_a, sat2_a}, 2'b00);
    chk("rst_anyf", anyf_a, 1'b0);
    reset_n = 1'b1;
    tick(2);
    chk("idle_wait", u_a.r_state, ST_IDLE);

    // ten 4-cycle error_1 pulses inside the window
    pulse_start_a();
    chk("t1_settle", u_a.r_state, ST_SETTLE);
    chk("t1_busy", busy_a, 1'b1);
    tick(16);
    chk("t1_count", u_a.r_state, ST_COUNT);
    for (int i = 0; i < 10; i++) begin
      e1_a = 1'b1; tick(4);
      e1_a = 1'b0; tick(20);
    end
    tick(8192 - 240 - 1);
    chk("t1_predone", done_a, 1'b0);
    tick(1);
    chk("t1_done", done_a, 1'b1);
    chk("t1_busy_off", busy_a, 1'b0);
    chk("t1_fc1", fc1_a, 16'd10);
    chk("t1_fc2", fc2_a, 16'd0);
    chk("t1_sat1", sat1_a, 1'b0);
    chk("t1_anyf", anyf_a, 1'b1);

    // error_2 held high through the window: one edge only
    pulse_start_a();
    chk("t2_clear_fc1", fc1_a, 16'd0);
    chk("t2_clear_anyf", anyf_a, 1'b0);
    tick(16);
    e2_a = 1'b1;
    tick(8192);
    chk("t2_done", done_a, 1'b1);
    chk("t2_fc2", fc2_a, 16'd1);
    chk("t2_fc1", fc1_a, 16'd0);
    chk("t2_anyf", anyf_a, 1'b1);
    e2_a = 1'b0;
    tick(4);

    // events only during SETTLE and DONE
    pulse_start_a();
    e1_a = 1'b1; tick(2); e1_a = 1'b0; tick(2);
    e1_a = 1'b1; tick(2); e1_a = 1'b0; tick(2);
    chk("t3_settle_fc1", fc1_a, 16'd0);
    chk("t3_settle_st", u_a.r_state, ST_SETTLE);
    tick(8);
    tick(8192);
    chk("t3_done", done_a, 1'b1);
    e1_a = 1'b1; tick(2); e1_a = 1'b0; tick(2);
    e1_a = 1'b1; tick(2); e1_a = 1'b0; tick(6);
    chk("t3_fc1", fc1_a, 16'd0);
    chk("t3_hold_done", done_a, 1'b1);

    // restart at COUNT cycle 100 after 5 events, then full rerun
    pulse_start_a();
    tick(16);
    for (int i = 0; i < 5; i++) begin
      e1_a = 1'b1; tick(2);
      e1_a = 1'b0; tick(4);
    end
    tick(70);
    chk("t4_fc1_pre", fc1_a, 16'd5);
    chk("t4_count_st", u_a.r_state, ST_COUNT);
    pulse_start_a();
    chk("t4_fc1_clr", fc1_a, 16'd0);
    chk("t4_settle_st", u_a.r_state, ST_SETTLE);
    chk("t4_busy", busy_a, 1'b1);
    tick(16);
    chk("t4_count2_st", u_a.r_state, ST_COUNT);
    tick(8191);
    chk("t4_last_count", u_a.r_state, ST_COUNT);
    chk("t4_predone", done_a, 1'b0);
    tick(1);
    chk("t4_done", done_a, 1'b1);
    chk("t4_fc1", fc1_a, 16'd0);

    // simultaneous events, then asynchronous reset mid-COUNT
    pulse_start_a();
    tick(16);
    e1_a = 1'b1; e2_a = 1'b1; tick(3);
    e1_a = 1'b0; e2_a = 1'b0; tick(5);
    chk("t5_fc1", fc1_a, 16'd1);
    chk("t5_fc2", fc2_a, 16'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_ar_state", u_a.r_state, ST_IDLE);
    chk("t5_ar_fc", {fc1_a, fc2_a}, 32'd0);
    chk("t5_ar_flags", {busy_a, done_a, sat1_a, sat2_a, anyf_a}, 5'b0);
    #2 reset_n = 1'b1;
    tick(20);
    chk("t5_idle", u_a.r_state, ST_IDLE);
    chk("t5_idle_busy", busy_a, 1'b0);

    // small instance: no settle phase, saturation at 15
    pulse_start_b();
    chk("t6_direct_count", u_b.r_state, ST_COUNT);
    chk("t6_busy", busy_b, 1'b1);
    for (int i = 0; i < 20; i++) begin
      e1_b = 1'b1; tick(1);
      e1_b = 1'b0; tick(1);
    end
    tick(4);
    chk("t6_fc1", fc1_b, 4'd15);
    chk("t6_sat1", sat1_b, 1'b1);
    chk("t6_sat2", sat2_b, 1'b0);
    chk("t6_fc2", fc2_b, 4'd0);
    tick(19);
    chk("t6_predone", done_b, 1'b0);
    tick(1);
    chk("t6_done", done_b, 1'b1);
    chk("t6_hold", {fc1_b, sat1_b, anyf_b}, {4'd15, 1'b1, 1'b1});

    // event detected on the final COUNT cycle is counted
    pulse_start_b();
    chk("t7_clr", {fc1_b, sat1_b}, 5'd0);
    tick(61);
    e1_b = 1'b1;
    tick(3);
    chk("t7_done", done_b, 1'b1);
    chk("t7_fc1", fc1_b, 4'd1);
    e1_b = 1'b0;
    tick(4);

    // one cycle later it falls into DONE and is ignored
    pulse_start_b();
    tick(62);
    e1_b = 1'b1;
    tick(3);
    chk("t8_done", done_b, 1'b1);
    chk("t8_fc1", fc1_b, 4'd0);
    e1_b = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
